// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared states, frame lengths and index width for the SPI memory slave
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    OP,
    ADDR,
    DATA,
    COMMIT,
    READ_WAIT,
    READ_SEND
  } state_t;

  localparam int WR_FRAME_BITS = 17;
  localparam int RD_FRAME_BITS = 9;
  localparam int IDX_W         = 5;
  localparam int ADDR_W        = RD_FRAME_BITS - 1;

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_W - 1);
  localparam logic [3:0] DATA_LAST = 4'(WR_FRAME_BITS - RD_FRAME_BITS - 1);

endpackage

// File: rtl/spi_mem_array.sv
// rtl/spi_mem_array.sv - word storage, sync write / async read; SPI_MEM_SLAVE_INIT_EN loads mem[i] = i on rst
module spi_mem_array
  import spi_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk_i,
`ifdef SPI_MEM_SLAVE_INIT_EN
  input  logic              rst_i,
`endif
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef SPI_MEM_SLAVE_INIT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(i);
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
`endif

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_mem_slave.sv
// rtl/spi_mem_slave.sv - clk-sampled SPI frame slave over a word memory; honours SPI_MEM_SLAVE_INIT_EN
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int READ_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done
);

  localparam int BIT_IW = $clog2(DATA_W);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [3:0]        lat_q;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_word_q, mem_rdata;
  logic              miso_q, ready_q, op_done_q;
  logic              wr_en;

  assign addr_d = {mosi, addr_q[ADDR_W-1:1]};
  assign data_d = {mosi, data_q[DATA_W-1:1]};
  assign wr_en  = (state_q == COMMIT) && !rst;

  spi_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
`ifdef SPI_MEM_SLAVE_INIT_EN
    .rst_i   (rst),
`endif
    .we_i    (wr_en),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (data_q),
    .raddr_i (addr_d[IDX_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // IDLE waits for cs high so a frame can only start after the master releases cs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_q     <= '0;
      op_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_word_q <= '0;
      miso_q    <= 1'b0;
      ready_q   <= 1'b0;
      op_done_q <= 1'b0;
    end else begin
      miso_q    <= 1'b0;
      ready_q   <= 1'b0;
      op_done_q <= 1'b0;
      case (state_q)
        IDLE:  if (cs) state_q <= ALIGN;
        ALIGN: if (!cs) state_q <= OP;
        OP: begin
          if (cs) begin
            state_q <= IDLE;
          end else begin
            op_q    <= mosi;
            cnt_q   <= '0;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (cs) begin
            state_q <= IDLE;
          end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_q + 4'd1;
            if (cnt_q == ADDR_LAST) begin
              cnt_q <= '0;
              if (op_q) begin
                state_q <= DATA;
              end else begin
                rd_word_q <= mem_rdata;
                lat_q     <= 4'(READ_LAT);
                state_q   <= READ_WAIT;
              end
            end
          end
        end
        DATA: begin
          if (cs) begin
            state_q <= IDLE;
          end else begin
            data_q <= data_d;
            cnt_q  <= cnt_q + 4'd1;
            if (cnt_q == DATA_LAST) state_q <= COMMIT;
          end
        end
        COMMIT: begin
          op_done_q <= 1'b1;
          state_q   <= IDLE;
        end
        READ_WAIT: begin
          lat_q <= lat_q - 4'd1;
          if (lat_q == 4'd1) begin
            ready_q <= 1'b1;
            miso_q  <= rd_word_q[0];
            cnt_q   <= '0;
            state_q <= READ_SEND;
          end
        end
        READ_SEND: begin
          miso_q <= rd_word_q[cnt_q[BIT_IW-1:0]];
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == DATA_LAST) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso    = miso_q;
  assign ready   = ready_q;
  assign op_done = op_done_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// tb/tb_spi_mem_slave.sv - directed self-checking bench for spi_mem_slave
module tb_spi_mem_slave;
  import spi_mem_pkg::*;

  logic clk, rst, cs, mosi;
  logic miso, ready, op_done;
  int   n_checks = 0;
  int   n_errors = 0;

  spi_mem_slave dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .mosi    (mosi),
    .miso    (miso),
    .ready   (ready),
    .op_done (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Leaves cs low; returns at the negedge after the last driven bit was sampled.
  task automatic frame(input logic op, input logic [7:0] a, input logic [7:0] d, input int nbits);
    logic [16:0] b;
    b    = {d, a, op};
    cs   = 1'b0;
    mosi = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[i];
      @(negedge clk);
    end
  endtask

  task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    frame(1'b1, a, d, 17);
    cs = 1'b1;
    check({tag, "_pre"}, 32'(op_done), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(op_done), 32'd1);
    @(negedge clk);
    check({tag, "_post"}, 32'(op_done), 32'd0);
    idle(2);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, output logic [7:0] w);
    logic m0;
    frame(1'b0, a, 8'h00, 9);
    cs = 1'b1;
    @(negedge clk);
    check({tag, "_rdy_early"}, 32'(ready), 32'd0);
    @(negedge clk);
    check({tag, "_rdy"}, 32'(ready), 32'd1);
    m0 = miso;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      w[j-1] = miso;
      if (j == 1) check({tag, "_rdy_pulse"}, 32'(ready), 32'd0);
    end
    check({tag, "_miso_T"}, 32'(m0), 32'(w[0]));
    @(negedge clk);
    check({tag, "_miso_tail"}, 32'(miso), 32'd0);
    idle(2);
  endtask

  initial begin
    logic [7:0] w;
    int pulses;
    rst  = 1'b1;
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_op_done", 32'(op_done), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    idle(2);

    do_write("wr05", 8'h05, 8'hA7);
    do_read("rd05", 8'h05, w);
    check("rd05_word", 32'(w), 32'h0000_00A7);

    do_write("wr03", 8'h03, 8'h5A);
    frame(1'b1, 8'h03, 8'hFF, 10);
    cs = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (op_done) pulses++;
    end
    check("abort_no_op_done", 32'(pulses), 32'd0);
    do_read("rd03", 8'h03, w);
    check("abort_mem_kept", 32'(w), 32'h0000_005A);

    do_write("wr1e", 8'h1E, 8'h77);
    do_write("wr25", 8'h25, 8'h11);
    do_read("rd05b", 8'h05, w);
    check("alias_word", 32'(w), 32'h0000_0011);

    // cs held low after a write must not start another frame
    frame(1'b1, 8'h07, 8'hC3, 17);
    mosi = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (op_done) pulses++;
    end
    check("cs_low_hold_pulses", 32'(pulses), 32'd1);
    check("cs_low_hold_state", 32'(dut.state_q), 32'(IDLE));
    idle(2);
    do_read("rd07", 8'h07, w);
    check("rd07_word", 32'(w), 32'h0000_00C3);

    frame(1'b0, 8'h05, 8'h00, 9);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    check("midrd_in_send", 32'(dut.state_q), 32'(READ_SEND));
    rst = 1'b1;
    @(negedge clk);
    check("midrd_miso", 32'(miso), 32'd0);
    check("midrd_ready", 32'(ready), 32'd0);
    check("midrd_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    idle(2);

    do_read("rd1e", 8'h1E, w);
`ifdef SPI_MEM_SLAVE_INIT_EN
    check("init_word", 32'(w), 32'h0000_001E);
`else
    check("retain_word", 32'(w), 32'h0000_0077);
`endif

    do_write("wr1f", 8'h1F, 8'h3C);
    do_read("rd1f", 8'h1F, w);
    check("rd1f_word", 32'(w), 32'h0000_003C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
